cpu: RTL and testbench

Minimal 4-bit accumulator processor with a 16-word × 4-bit unified program/data memory and a 4-bit program counter. It fetches and executes one instruction at a time and exposes the accumulator as its only output. It is a self-contained top-level block: no external bus, no I/O other than clock, reset and `acc`. Verification reads and writes internal `memory` and `PC` through hierarchical references.

---
 rtl/cpu.sv | 100 ++++++++++
 tb/tb_cpu.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/cpu.sv
// ------------------------------------------------------------------
// cpu: 4-bit accumulator core, 16x4 unified program/data memory.
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

module cpu (
  input  wire logic       clk,
  input  wire logic       reset,
  output logic      [3:0] acc
);

  localparam logic [1:0] FETCH   = 2'd0;
  localparam logic [1:0] OPERAND = 2'd1;
  localparam logic [1:0] EXECUTE = 2'd2;
  localparam logic [1:0] HALT    = 2'd3;

  localparam logic [3:0] OP_LOAD  = 4'd1;
  localparam logic [3:0] OP_ADD   = 4'd2;
  localparam logic [3:0] OP_SUB   = 4'd3;
  localparam logic [3:0] OP_AND   = 4'd4;
  localparam logic [3:0] OP_OR    = 4'd5;
  localparam logic [3:0] OP_STORE = 4'd6;
  localparam logic [3:0] OP_JMP   = 4'd7;
  localparam logic [3:0] OP_HALT  = 4'd15;

  logic [3:0] memory [0:15];
  logic [3:0] PC;
  logic [3:0] IR;
  logic [3:0] OPR;
  logic [3:0] R1;
  logic [1:0] state;

  logic [3:0] w_pc_word;
  logic [3:0] w_pc_inc;
  logic       w_alu_op;
  logic [3:0] w_r1_next;
  logic       w_store;

  assign w_pc_word = memory[PC];
  assign w_pc_inc  = PC + 4'd1;
  assign w_alu_op  = (state == EXECUTE) && (IR >= OP_ADD) && (IR <= OP_OR);
  // R1 captures the memory operand in the same edge the ALU consumes it
  assign w_r1_next = w_alu_op ? memory[OPR] : R1;
  assign w_store   = (state == EXECUTE) && (IR == OP_STORE);

  always_ff @(posedge clk) begin
    if (reset) begin
      acc   <= 4'd0;
      PC    <= 4'd0;
      IR    <= 4'd0;
      OPR   <= 4'd0;
      R1    <= 4'd0;
      state <= FETCH;
    end else begin
      R1 <= w_r1_next;
      case (state)
        FETCH: begin
          IR <= w_pc_word;
          PC <= w_pc_inc;
          if ((w_pc_word >= OP_LOAD) && (w_pc_word <= OP_JMP)) begin
            state <= OPERAND;
          end else if (w_pc_word == OP_HALT) begin
            state <= HALT;
          end else begin
            state <= FETCH;
          end
        end
        OPERAND: begin
          OPR   <= w_pc_word;
          PC    <= w_pc_inc;
          state <= EXECUTE;
        end
        EXECUTE: begin
          case (IR)
            OP_LOAD: acc <= OPR;
            OP_ADD:  acc <= acc + w_r1_next;
            OP_SUB:  acc <= acc - w_r1_next;
            OP_AND:  acc <= acc & w_r1_next;
            OP_OR:   acc <= acc | w_r1_next;
            OP_JMP:  PC  <= OPR;
            default: acc <= acc;
          endcase
          state <= FETCH;
        end
        default: state <= HALT;
      endcase
    end
  end

  // Memory is never cleared by reset; a reset edge cancels a pending STORE
  always_ff @(posedge clk) begin
    if (!reset && w_store) begin
      memory[OPR] <= acc;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cpu.sv
// ------------------------------------------------------------------
// tb_cpu: directed program checks plus random programs vs an ISA model.
// ------------------------------------------------------------------
`default_nettype none

module tb_cpu;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] acc;

  int total = 0;
  int bad   = 0;

  int m_mem [16];
  int m_pc;
  int m_acc;
  bit m_halted;

  cpu dut (
    .clk   (clk),
    .reset (reset),
    .acc   (acc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic load_prog(input int w0, input int w1, input int w2, input int w3,
                           input int w4, input int w5, input int w6, input int w7);
    int p [8];
    p = '{w0, w1, w2, w3, w4, w5, w6, w7};
    for (int i = 0; i < 16; i++) dut.memory[i] = 4'd0;
    for (int i = 0; i < 8; i++) dut.memory[i] = 4'(p[i]);
  endtask

  // Executes one whole instruction at ISA level; returns its cycle count
  function automatic int model_step();
    int op, opr;
    op = m_mem[m_pc];
    m_pc = (m_pc + 1) % 16;
    if (op == 15) begin
      m_halted = 1'b1;
      return 1;
    end
    if (op < 1 || op > 7) return 1;
    opr = m_mem[m_pc];
    m_pc = (m_pc + 1) % 16;
    case (op)
      1: m_acc = opr;
      2: m_acc = (m_acc + m_mem[opr]) % 16;
      3: m_acc = (m_acc + 16 - m_mem[opr]) % 16;
      4: m_acc = m_acc & m_mem[opr];
      5: m_acc = m_acc | m_mem[opr];
      6: m_mem[opr] = m_acc;
      default: m_pc = opr;
    endcase
    return 3;
  endfunction

  initial begin
    logic [3:0] snap [16];
    int cyc;

    // Reset: preloaded memory survives, registers clear
    for (int i = 0; i < 16; i++) begin
      snap[i] = 4'($urandom_range(0, 15));
      dut.memory[i] = snap[i];
    end
    do_reset();
    check("reset_acc", acc, 4'd0);
    check("reset_pc", dut.PC, 4'd0);
    for (int i = 0; i < 16; i++) check("reset_mem_kept", dut.memory[i], snap[i]);

    // NOP timing
    load_prog(0, 0, 0, 0, 0, 0, 0, 0);
    do_reset();
    tick(1); check("nop_pc1", dut.PC, 4'd1);
    tick(1); check("nop_pc2", dut.PC, 4'd2);
    tick(1); check("nop_pc3", dut.PC, 4'd3);
    check("nop_acc", acc, 4'd0);

    // Arithmetic sequence then OR
    load_prog(1, 3, 2, 12, 3, 13, 4, 14);
    dut.memory[8] = 4'd5; dut.memory[9] = 4'd15;
    dut.memory[12] = 4'd5; dut.memory[13] = 4'd2; dut.memory[14] = 4'd6;
    dut.memory[15] = 4'd9;
    do_reset();
    tick(3); check("arith_load", acc, 4'd3);
    tick(3); check("arith_add", acc, 4'd8);
    tick(3); check("arith_sub", acc, 4'd6);
    tick(3); check("arith_and", acc, 4'd6);
    tick(3); check("arith_or", acc, 4'd15);

    // Modulo-16 wrap and STORE
    load_prog(1, 15, 2, 11, 1, 14, 6, 10);
    dut.memory[11] = 4'd1;
    do_reset();
    tick(6); check("wrap_add", acc, 4'd0);
    tick(3); check("store_acc", acc, 4'd14);
    tick(2); check("store_before", dut.memory[10], 4'd0);
    tick(1); check("store_after", dut.memory[10], 4'd14);

    // JMP then fetch at the target
    load_prog(7, 2, 1, 9, 0, 0, 0, 0);
    do_reset();
    tick(3); check("jmp_pc", dut.PC, 4'd2);
    tick(3); check("jmp_target_exec", acc, 4'd9);

    // Opcode at 15 takes its operand from address 0
    load_prog(7, 15, 0, 0, 0, 0, 0, 0);
    dut.memory[15] = 4'd1;
    do_reset();
    tick(3); check("wrap_jmp_pc", dut.PC, 4'd15);
    tick(3); check("wrap_operand", acc, 4'd7);
    check("wrap_pc", dut.PC, 4'd1);

    // HALT freezes PC and acc
    load_prog(1, 5, 15, 1, 9, 0, 0, 0);
    do_reset();
    tick(4);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("halt_pc", dut.PC, 4'd3);
      check("halt_acc", acc, 4'd5);
    end

    // Reset during OPERAND cancels the LOAD
    load_prog(1, 5, 1, 9, 0, 0, 0, 0);
    do_reset();
    tick(4);
    check("mid_pre_acc", acc, 4'd5);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("mid_acc", acc, 4'd0);
    check("mid_pc", dut.PC, 4'd0);
    tick(3);
    check("mid_restart", acc, 4'd5);

    // Random programs against the ISA-level model
    for (int p = 0; p < 12; p++) begin
      for (int i = 0; i < 16; i++) begin
        m_mem[i] = $urandom_range(0, 15);
        if (m_mem[i] == 15 && ($urandom_range(0, 3) != 0)) m_mem[i] = $urandom_range(1, 7);
        dut.memory[i] = 4'(m_mem[i]);
      end
      m_pc = 0;
      m_acc = 0;
      m_halted = 1'b0;
      do_reset();
      for (int s = 0; s < 30 && !m_halted; s++) begin
        cyc = model_step();
        tick(cyc);
        check("rnd_acc", acc, 4'(m_acc));
        check("rnd_pc", dut.PC, 4'(m_pc));
        for (int i = 0; i < 16; i++) check("rnd_mem", dut.memory[i], 4'(m_mem[i]));
      end
      if (m_halted) begin
        tick(3);
        check("rnd_halt_pc", dut.PC, 4'(m_pc));
        check("rnd_halt_acc", acc, 4'(m_acc));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
